seq_shift_add_mult: RTL

//  Parametrised sequential shift-and-add multiplier, next generation of the datapath

---
 rtl/seq_shift_add_mult.sv | 102 ++++++++++
 1 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement per operation, start/busy/done handshake, held registered product.
module seq_shift_add_mult #(
  parameter  int unsigned WA = 8,
  parameter  int unsigned WB = 4,
  localparam int unsigned WP = WA + WB
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [WP-1:0] product
);

  // Counter must reach WB after the last processing edge.
  localparam int unsigned CW = $clog2(WB + 1);
  localparam logic [CW-1:0] LAST = CW'(WB - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [WA-1:0] mag_a;
  logic [WB-1:0] mag_b;
  logic          neg;
  logic [WP-1:0] acc;

  logic [WA-1:0] mag_a_in;
  logic [WB-1:0] mag_b_in;
  logic          neg_in;
  logic [WP-1:0] addend;
  logic [WP-1:0] acc_next;
  logic [WP-1:0] result;

  // Operand magnitudes and result sign; |most-negative| fits the unsigned register.
  always_comb begin
    mag_a_in = a;
    mag_b_in = b;
    neg_in   = signed_mode & (a[WA-1] ^ b[WB-1]);
    if (signed_mode && a[WA-1]) mag_a_in = '0 - a;
    if (signed_mode && b[WB-1]) mag_b_in = '0 - b;
  end

  // Partial-product accumulation and final sign application (zero stays zero).
  always_comb begin
    addend   = '0;
    if (mag_b[0]) addend = WP'(mag_a) << counter;
    acc_next = acc + addend;
    result   = neg ? ('0 - acc_next) : acc_next;
  end

  // Control FSM with datapath registers; busy/done/product are registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      counter <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Only the result sign is kept from the mode; magnitudes are unsigned.
            mag_a   <= mag_a_in;
            mag_b   <= mag_b_in;
            neg     <= neg_in;
            acc     <= '0;
            counter <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_next;
          mag_b   <= mag_b >> 1;
          counter <= counter + CW'(1);
          if (counter == LAST) begin
            product <= result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
